// File: rtl/status_cond_unit.sv
// Architectural status register {N,Z,C,V} plus ARM condition-code evaluation for ID.
// Define STATUS_BYPASS_EN to forward EXE statusIn into the evaluation instead of stalling.
module status_cond_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       statusIn,
  input  logic             sUpdate,
  input  logic [3:0]       condIn,
  input  logic             idValid,
  input  logic             stall,
  input  logic             flush,
  input  logic             cntClr,
  output logic [3:0]       sr,
  output logic             carryOut,
  output logic             condPass,
  output logic             flagHazard,
  output logic [CNT_W-1:0] skipCount
);

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       sr_q, sr_d;
  logic             cond_pass_q, cond_pass_d;
  logic [CNT_W-1:0] skip_q, skip_d;

  logic [3:0] flags_eff;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       pass;
  logic       hazard;
  logic       issue;

`ifdef STATUS_BYPASS_EN
  // The whole nibble is forwarded together so old and new flag bits never mix.
  assign flags_eff = sUpdate ? statusIn : sr_q;
  assign hazard    = 1'b0;
`else
  assign flags_eff = sr_q;
  assign hazard    = idValid & sUpdate & (condIn != COND_AL);
`endif

  assign {flag_n, flag_z, flag_c, flag_v} = flags_eff;

  always_comb begin
    pass = 1'b0;
    case (condIn)
      4'b0000: pass = flag_z;
      4'b0001: pass = ~flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = ~flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = ~flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = ~flag_v;
      4'b1000: pass = flag_c & ~flag_z;
      4'b1001: pass = ~flag_c | flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = ~flag_z & (flag_n == flag_v);
      4'b1101: pass = flag_z | (flag_n != flag_v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign issue = idValid & ~stall & ~flush & ~hazard;

  always_comb begin
    sr_d        = sUpdate ? statusIn : sr_q;
    cond_pass_d = (flush | stall | hazard) ? 1'b0 : (idValid & pass);
    skip_d      = skip_q;
    if (cntClr) begin
      skip_d = '0;
    end else if (issue && !pass && (skip_q != CNT_MAX)) begin
      skip_d = skip_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q        <= 4'b0000;
      cond_pass_q <= 1'b0;
      skip_q      <= '0;
    end else begin
      sr_q        <= sr_d;
      cond_pass_q <= cond_pass_d;
      skip_q      <= skip_d;
    end
  end

  assign sr         = sr_q;
  assign carryOut   = sr_q[1];
  assign condPass   = cond_pass_q;
  assign flagHazard = hazard;
  assign skipCount  = skip_q;

endmodule
